// File: rtl/lsu_dmem.sv
// lsu_dmem - load/store unit between the execute stage and port B of the
// 1 KB dual-port byte-enable data BRAM (512 x 16-bit words, two byte lanes).
//
// Converts byte-addressed 8/16-bit core requests into word accesses with
// per-lane write enables, sign/zero-extends loaded bytes, and absorbs the
// BRAM's one-cycle registered read latency (one registered result per load).
//
// Build option: define LSU_MISALIGN_EN to split misaligned halfword accesses
// into two word accesses (o_err tied low). Without it, misaligned halfwords
// make no BRAM access and are reported with a one-cycle o_err pulse.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_req/o_ready           request handshake (accepted when both high)
//   i_we, i_size, i_signed  store/load, byte/half, sign/zero extend
//   i_addr, i_wdata         byte address, store data
//   o_rvalid, o_rdata       load result pulse / held result
//   o_err                   misaligned-access pulse
//   o_b_*, i_b_dout_*       BRAM port B (combinational drive, registered read)
module lsu_dmem (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic        i_size,
   input  logic        i_signed,
   input  logic [9:0]  i_addr,
   input  logic [15:0] i_wdata,
   output logic        o_ready,
   output logic        o_rvalid,
   output logic [15:0] o_rdata,
   output logic        o_err,
   output logic        o_b_en,
   output logic        o_b_we_h,
   output logic        o_b_we_l,
   output logic [8:0]  o_b_addr,
   output logic [7:0]  o_b_din_h,
   output logic [7:0]  o_b_din_l,
   input  logic [7:0]  i_b_dout_h,
   input  logic [7:0]  i_b_dout_l
);

`ifdef LSU_MISALIGN_EN
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_MIS, RD_MIS2, WR_MIS} state_t;
`else
   typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;
`endif

   state_t      state;
   logic [8:0]  r_waddr;
   logic [7:0]  r_wdata_h;
   logic        r_signed;
   logic        r_lane;
   logic        r_half;
`ifdef LSU_MISALIGN_EN
   logic [7:0]  r_lo;
`else
   logic        r_mis;
   logic        r_err;
`endif

   logic        accept;
   logic        mis;
   logic [7:0]  sel_byte;
   logic [15:0] load_word;

   // State is forced to IDLE asynchronously, so gating ready with reset also
   // keeps every port B enable low while reset is held.
   assign o_ready = (state == IDLE) & i_rst_n;
   assign accept  = i_req & o_ready;
   assign mis     = i_size & i_addr[0];

   assign sel_byte  = r_lane ? i_b_dout_h : i_b_dout_l;
   assign load_word = r_half ? {i_b_dout_h, i_b_dout_l}
                             : {(r_signed ? {8{sel_byte[7]}} : 8'h00), sel_byte};

`ifdef LSU_MISALIGN_EN
   assign o_err = 1'b0;
`else
   assign o_err = r_err;
`endif

   always_comb begin
      o_b_en    = 1'b0;
      o_b_we_h  = 1'b0;
      o_b_we_l  = 1'b0;
      o_b_addr  = r_waddr;
      o_b_din_h = r_wdata_h;
      o_b_din_l = r_wdata_h;
      case (state)
         IDLE: begin
            o_b_addr  = i_addr[9:1];
            // high lane carries wdata[15:8] only for an aligned halfword;
            // byte stores and the first half of a split store use wdata[7:0]
            o_b_din_h = (i_size & ~i_addr[0]) ? i_wdata[15:8] : i_wdata[7:0];
            o_b_din_l = i_wdata[7:0];
            if (accept) begin
`ifdef LSU_MISALIGN_EN
               o_b_en = 1'b1;
`else
               o_b_en = ~mis;
`endif
               if (i_we) begin
                  if (!i_size) begin
                     o_b_we_l = ~i_addr[0];
                     o_b_we_h = i_addr[0];
                  end else if (!i_addr[0]) begin
                     o_b_we_l = 1'b1;
                     o_b_we_h = 1'b1;
                  end else begin
`ifdef LSU_MISALIGN_EN
                     o_b_we_h = 1'b1;
`endif
                  end
               end
            end
         end
`ifdef LSU_MISALIGN_EN
         RD_MIS: begin
            o_b_en   = 1'b1;
            o_b_addr = r_waddr + 9'd1;
         end
         WR_MIS: begin
            o_b_en    = 1'b1;
            o_b_we_l  = 1'b1;
            o_b_addr  = r_waddr + 9'd1;
            o_b_din_l = r_wdata_h;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         o_rvalid  <= 1'b0;
         o_rdata   <= '0;
         r_waddr   <= '0;
         r_wdata_h <= '0;
         r_signed  <= 1'b0;
         r_lane    <= 1'b0;
         r_half    <= 1'b0;
`ifdef LSU_MISALIGN_EN
         r_lo      <= '0;
`else
         r_mis     <= 1'b0;
         r_err     <= 1'b0;
`endif
      end else begin
         o_rvalid <= 1'b0;
`ifndef LSU_MISALIGN_EN
         r_err    <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (accept) begin
                  r_waddr   <= i_addr[9:1];
                  r_wdata_h <= i_wdata[15:8];
                  r_signed  <= i_signed;
                  r_lane    <= i_addr[0];
                  r_half    <= i_size;
`ifdef LSU_MISALIGN_EN
                  if (!i_we)
                     state <= mis ? RD_MIS : RD_WAIT;
                  else if (mis)
                     state <= WR_MIS;
`else
                  r_mis <= mis;
                  if (!i_we)
                     state <= RD_WAIT;
                  else if (mis)
                     r_err <= 1'b1;
`endif
               end
            end
            RD_WAIT: begin
               o_rvalid <= 1'b1;
               state    <= IDLE;
`ifdef LSU_MISALIGN_EN
               o_rdata  <= load_word;
`else
               if (r_mis) begin
                  o_rdata <= '0;
                  r_err   <= 1'b1;
               end else begin
                  o_rdata <= load_word;
               end
`endif
            end
`ifdef LSU_MISALIGN_EN
            // low result byte is staged in r_lo so o_rdata holds the previous
            // result until the combined value is presented with o_rvalid
            RD_MIS: begin
               r_lo  <= i_b_dout_h;
               state <= RD_MIS2;
            end
            RD_MIS2: begin
               o_rdata  <= {i_b_dout_l, r_lo};
               o_rvalid <= 1'b1;
               state    <= IDLE;
            end
            WR_MIS: state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem - self-checking bench for lsu_dmem with a behavioural BRAM and
// a byte-array reference model of the 1 KB data memory.
module tb_lsu_dmem;

`ifdef LSU_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, size = 1'b0, sgn = 1'b0;
   logic [9:0]  addr = '0;
   logic [15:0] wdata = '0;
   logic        o_ready, o_rvalid, o_err;
   logic [15:0] o_rdata;
   logic        b_en, b_we_h, b_we_l;
   logic [8:0]  b_addr;
   logic [7:0]  b_din_h, b_din_l, dout_h, dout_l;

   lsu_dmem dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
      .i_signed(sgn), .i_addr(addr), .i_wdata(wdata),
      .o_ready(o_ready), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
      .o_b_en(b_en), .o_b_we_h(b_we_h), .o_b_we_l(b_we_l), .o_b_addr(b_addr),
      .o_b_din_h(b_din_h), .o_b_din_l(b_din_l),
      .i_b_dout_h(dout_h), .i_b_dout_l(dout_l)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(int i);
      int v;
      v = i * 40503 + 7919;
      return v[15:0];
   endfunction

   // behavioural BRAM port B: byte-lane writes, registered read
   logic [15:0] mem [512];
   logic        mem_init = 1'b1;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 512; i++) mem[i] <= pat(i);
      end else if (b_en) begin
         if (b_we_h) mem[b_addr][15:8] <= b_din_h;
         if (b_we_l) mem[b_addr][7:0]  <= b_din_l;
         dout_h <= mem[b_addr][15:8];
         dout_l <= mem[b_addr][7:0];
      end
   end

   // reference model: flat little-endian byte array
   logic [7:0] rm [1024];

   int cmp = 0;
   int bad = 0;
   int last_wait = 0;

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      cmp++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wchk(string tag, int w);
      chk(tag, mem[w], {rm[2*w+1], rm[2*w]});
   endtask

   // Presents one request at a negedge, lets it be accepted, returns at the
   // negedge after the accept edge with the reference model updated.
   task automatic issue(bit w, bit s, bit g, logic [9:0] a, logic [15:0] d);
      int n;
      bit drop;
      n = 0;
      while (!o_ready && n < 8) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      chk("ready_before_issue", {15'd0, o_ready}, 16'd1);
      drop = s && a[0] && !MIS_EN;
      req = 1'b1; we = w; size = s; sgn = g; addr = a; wdata = d;
      #1;
      chk("b_en_accept", {15'd0, b_en}, {15'd0, !drop});
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      we = 1'($urandom); size = 1'($urandom); addr = 10'($urandom); wdata = 16'($urandom);
      if (w && !drop) begin
         rm[a] = d[7:0];
         if (s) rm[10'(a + 1)] = d[15:8];
      end
   endtask

   task automatic st(bit s, logic [9:0] a, logic [15:0] d);
      issue(1'b1, s, 1'b0, a, d);
      chk("store_no_rvalid", {15'd0, o_rvalid}, 16'd0);
      chk("store_err", {15'd0, o_err}, {15'd0, (s && a[0] && !MIS_EN)});
   endtask

   task automatic ld(bit s, bit g, logic [9:0] a);
      logic [15:0]        exp;
      logic signed [15:0] sx;
      bit                 err_exp;
      int                 lat_exp, lat;
      bit                 m;
      m = s && a[0];
      if (m && !MIS_EN) begin
         exp = 16'h0000; err_exp = 1'b1; lat_exp = 1;
      end else begin
         err_exp = 1'b0;
         lat_exp = m ? 2 : 1;
         if (s) exp = {rm[10'(a + 1)], rm[a]};
         else if (g) begin
            sx  = $signed(rm[a]);
            exp = sx;
         end else exp = {8'h00, rm[a]};
      end
      issue(1'b0, s, g, a, 16'($urandom));
      chk("load_rvalid_early", {15'd0, o_rvalid}, 16'd0);
      lat = 0;
      while (!o_rvalid && lat < 6) begin
         @(negedge clk);
         lat++;
      end
      chk("load_latency", 16'(lat), 16'(lat_exp));
      chk("load_rdata", o_rdata, exp);
      chk("load_err", {15'd0, o_err}, {15'd0, err_exp});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] saved;
      int         rv;
      bit         rw, rs, rg;
      logic [9:0] ra;
      logic [9:0] edges [4];
      for (int b = 0; b < 1024; b++) begin
         logic [15:0] p;
         p = pat(b >> 1);
         rm[b] = b[0] ? p[15:8] : p[7:0];
      end

      // reset: requests must be ignored and port B idle
      @(negedge clk);
      mem_init = 1'b0;
      req = 1'b1; we = 1'b1; size = 1'b1; addr = 10'h004; wdata = 16'hFFFF;
      #1;
      chk("rst_ready", {15'd0, o_ready}, 16'd0);
      chk("rst_en", {15'd0, b_en}, 16'd0);
      chk("rst_we", {14'd0, b_we_h, b_we_l}, 16'd0);
      chk("rst_rvalid", {15'd0, o_rvalid}, 16'd0);
      chk("rst_rdata", o_rdata, 16'h0000);
      chk("rst_err", {15'd0, o_err}, 16'd0);
      @(negedge clk);
      req = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // aligned half store / load
      st(1'b1, 10'h004, 16'h1234);
      chk("word2_view", mem[2], 16'h1234);
      ld(1'b1, 1'b0, 10'h004);
      chk("ld004_const", o_rdata, 16'h1234);

      // byte store to high lane, signed and unsigned reload
      st(1'b0, 10'h011, 16'hE785);
      ld(1'b0, 1'b1, 10'h011);
      chk("ldb_signed_const", o_rdata, 16'hFF85);
      ld(1'b0, 1'b0, 10'h011);
      chk("ldb_unsigned_const", o_rdata, 16'h0085);
      chk("word8_low_kept", {8'h00, mem[8][7:0]}, {8'h00, rm[16]});

      // misaligned halfword at the top of memory
      if (MIS_EN) begin
         saved = rm[0];
         st(1'b1, 10'h3FF, 16'hABCD);
         chk("mis_st_first_half", {8'h00, mem[9'h1FF][15:8]}, 16'h00CD);
         chk("mis_st_second_pending", {8'h00, mem[0][7:0]}, {8'h00, saved});
         @(negedge clk);
         chk("mis_st_second_half", {8'h00, mem[0][7:0]}, 16'h00AB);
         ld(1'b1, 1'b0, 10'h3FF);
         chk("mis_ld_const", o_rdata, 16'hABCD);
      end else begin
         ld(1'b1, 1'b0, 10'h003);
         st(1'b1, 10'h003, 16'h5A5A);
         @(negedge clk);
         wchk("mis_st_word1", 1);
         wchk("mis_st_word2", 2);
      end

      // back-to-back aligned stores, then a load accepted in an rvalid cycle
      edges[0] = 10'h020; edges[1] = 10'h022; edges[2] = 10'h024; edges[3] = 10'h027;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) st(1'b0, edges[i], 16'h00C0 + 16'(i));
         else st(1'b1, edges[i], 16'h1100 * 16'(i + 1) + 16'(i));
         chk("b2b_store_wait", 16'(last_wait), 16'd0);
      end
      ld(1'b1, 1'b0, 10'h020);
      ld(1'b1, 1'b1, 10'h022);
      chk("b2b_load_wait", 16'(last_wait), 16'd0);
      ld(1'b0, 1'b0, 10'h027);
      for (int w = 16; w < 20; w++) wchk("b2b_words", w);

      // reset during the second half of a misaligned store
      if (MIS_EN) begin
         saved = rm[8];
         issue(1'b1, 1'b1, 1'b0, 10'h007, 16'h5AC3);
         rm[8] = saved;
         rst_n = 1'b0;
         #1;
         chk("abort_ready", {15'd0, o_ready}, 16'd0);
         chk("abort_en", {15'd0, b_en}, 16'd0);
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         chk("abort_ready_after", {15'd0, o_ready}, 16'd1);
         wchk("abort_word3", 3);
         wchk("abort_word4", 4);
      end

      // reset while a load is waiting for data: no response may follow
      issue(1'b0, 1'b0, 1'b0, 10'h010, 16'h0000);
      rst_n = 1'b0;
      #1;
      chk("ldabort_ready", {15'd0, o_ready}, 16'd0);
      chk("ldabort_en", {15'd0, b_en}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rv = 0;
      repeat (4) begin
         @(negedge clk);
         rv += int'(o_rvalid);
      end
      chk("ldabort_no_rvalid", 16'(rv), 16'd0);
      chk("ldabort_rdata_reset", o_rdata, 16'h0000);

      // randomized mix, biased toward the address ends
      for (int n = 0; n < 300; n++) begin
         rw = 1'($urandom);
         rs = 1'($urandom);
         rg = 1'($urandom);
         case ($urandom_range(0, 7))
            0: ra = 10'h000;
            1: ra = 10'h001;
            2: ra = 10'h3FE;
            3: ra = 10'h3FF;
            default: ra = 10'($urandom);
         endcase
         if (rw) st(rs, ra, 16'($urandom));
         else ld(rs, rg, ra);
      end
      @(negedge clk);
      @(negedge clk);
      ld(1'b1, 1'b0, 10'h100);
      @(negedge clk);
      chk("rdata_held_rvalid", {15'd0, o_rvalid}, 16'd0);
      chk("rdata_held", o_rdata, {rm[10'h101], rm[10'h100]});

      for (int w = 0; w < 512; w++) wchk("final_mem", w);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/lsu_dmem.md
# lsu_dmem

Load/store unit between the core's execute stage and data port B of the 1 KB dual-port byte-enable BRAM. It converts byte-addressed 8-/16-bit core requests into 16-bit word accesses with per-lane write enables. Misaligned halfword accesses are split into two word accesses, and loaded bytes are sign- or zero-extended. It absorbs the BRAM's one-cycle registered read latency and returns one registered result per load.

## Interface
Parameters: none; the address space is fixed at 1 KB (10-bit byte address, 9-bit word address).
- i_clk  in  1  sole clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  core request valid; accepted when i_req & o_ready
- i_we  in  1  1 = store, 0 = load
- i_size  in  1  0 = byte, 1 = halfword
- i_signed  in  1  load sign-extend (1) or zero-extend (0); ignored for stores
- i_addr  in  10  byte address; little-endian, addr[0]=0 selects low lane
- i_wdata  in  16  store data; byte stores use [7:0]
- o_ready  out  1  high only in IDLE while out of reset
- o_rvalid  out  1  one-cycle pulse with load result
- o_rdata  out  16  load result, held until next o_rvalid
- o_err  out  1  one-cycle misaligned-access pulse (see Configuration)
- o_b_en, o_b_we_h, o_b_we_l  out  1 each  BRAM port B enable / high-lane / low-lane write enables
- o_b_addr  out  9  BRAM word address
- o_b_din_h, o_b_din_l  out  8 each  BRAM write data lanes
- i_b_dout_h, i_b_dout_l  in  8 each  BRAM read data, valid the cycle after the enable edge

## Operation
- States: IDLE, RD_WAIT, RD_MIS, RD_MIS2, WR_MIS.
- Port B signals are driven combinationally. In IDLE they are driven from the core inputs when i_req is high. In the other states they are driven from registered request fields (word address, wdata, signed, lane).
- Aligned load (byte, or half with addr[0]=0): en=1, addr=i_addr[9:1], go to RD_WAIT. In RD_WAIT, register the result, pulse o_rvalid, return to IDLE.
- Byte load lane: addr[0]=0 gives dout_l, addr[0]=1 gives dout_h. Bits [15:8] = {8{byte[7]}} if signed, else 0. Halfword result = {dout_h, dout_l}.
- Misaligned half load (addr[0]=1):
  - IDLE issues word A and goes to RD_MIS.
  - RD_MIS captures dout_h as result[7:0], issues A+1, goes to RD_MIS2.
  - RD_MIS2 takes result[15:8] = dout_l, pulses o_rvalid, goes to IDLE.
  - A+1 wraps mod 512, so 0x1FF+1 = 0x000.
- Byte store: en=1, both din lanes = wdata[7:0], we_l = ~addr[0], we_h = addr[0]. Completes in the accept cycle; stay in IDLE.
- Aligned half store: we_h = we_l = 1, din_h = wdata[15:8], din_l = wdata[7:0]. Stay in IDLE.
- Misaligned half store: IDLE writes wdata[7:0] to A high lane and goes to WR_MIS. WR_MIS writes wdata[15:8] to A+1 low lane and goes to IDLE.
- No responses for stores; o_rvalid is never asserted by a store.
- Outside the active cycles listed above, en, we_h and we_l are 0.

## Timing
- Reset values: state IDLE, o_rvalid=0, o_rdata=0x0000, o_err=0. While i_rst_n is low: o_ready=0 and en, we_h, we_l = 0.
- Load accepted at edge k: o_rvalid is high in the cycle after edge k+1 (aligned) or k+2 (misaligned).
- o_ready is low in RD_WAIT, RD_MIS, RD_MIS2 and WR_MIS. A new request may be accepted in the same cycle o_rvalid is high.
- Throughput:
  - aligned stores: 1 per cycle
  - misaligned stores: 1 per 2 cycles
  - aligned loads: 1 per 2 cycles
  - misaligned loads: 1 per 3 cycles
- Reset asserted mid-operation aborts immediately. The pending second half of a misaligned store is not written; the first half remains. No o_rvalid follows.
- i_* inputs are sampled only when o_ready is high. Changes in non-IDLE states have no effect.

## Configuration
- LSU_MISALIGN_EN defined: misaligned halfword accesses are split as above, and o_err is tied 0.
- LSU_MISALIGN_EN undefined:
  - No BRAM access is made for a misaligned halfword; en stays 0.
  - Load: go to RD_WAIT; the next cycle pulses o_rvalid and o_err together with o_rdata=0x0000.
  - Store: o_err pulses in the cycle after accept; no write occurs.
  - States RD_MIS, RD_MIS2 and WR_MIS are not built.

## Test plan
- Reset release, then store half 0x1234 at 0x004, then load unsigned half 0x004 -> o_rvalid 2 cycles after accept, o_rdata=0x1234. Word 2 debug view = 0x1234.
- Store byte 0x85 at 0x011; signed byte load 0x011 -> 0xFF85; unsigned -> 0x0085. Word 8 low lane unchanged.
- LSU_MISALIGN_EN defined:
  - Store half 0xABCD at 0x3FF -> word 0x1FF high lane = 0xCD and word 0x000 low lane = 0xAB, on consecutive cycles.
  - Load half 0x3FF -> 0xABCD after 3 cycles.
- LSU_MISALIGN_EN undefined: load half 0x003 -> o_rvalid = o_err = 1 with o_rdata=0x0000, no en pulse. Store half at 0x003 -> o_err pulse, memory unchanged.
- Back-to-back: 4 aligned stores on consecutive cycles with o_ready held 1, then a load issued in the o_rvalid cycle of a previous load -> both results correct, no lost requests.
- i_rst_n dropped in the WR_MIS cycle of a misaligned store to 0x007 -> word 3 high lane written, word 4 low lane untouched, o_ready=0 during reset, IDLE after release.
